// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_pkg
// Brief    : Shared constants for the branch predict unit.
// Revision : 1.0 - initial release
// ============================================================================
package branch_pkg;

   // 2-bit reference encodings of the weak counter states. Wider counters
   // scale these up by shifting left, keeping the taken decision on the MSB.
   localparam logic [1:0] CNT_WEAK_NT = 2'b01;
   localparam logic [1:0] CNT_WEAK_T  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module   : branch_target_buffer
// Brief    : Direct-mapped BTB with per-entry saturating counters. One
//            combinational lookup port and one registered update port.
// Revision : 1.0 - initial release
// ============================================================================
module branch_target_buffer
   import branch_pkg::*;
#(
   parameter int PC_W    = 9,
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 2,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter int TAG_W   = PC_W - IDX_W - 2
) (
   input  logic             clk,
   input  logic             reset,
   // lookup port
   input  logic [IDX_W-1:0] rd_idx,
   input  logic [TAG_W-1:0] rd_tag,
   output logic             rd_taken,
   output logic [PC_W-1:0]  rd_target,
   // update port
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic [TAG_W-1:0] upd_tag,
   input  logic [PC_W-1:0]  upd_target,
   input  logic             upd_taken
);

   localparam logic [CNT_W-1:0] c_weak_t  = CNT_W'(CNT_WEAK_T) << (CNT_W - 2);
   localparam logic [CNT_W-1:0] c_weak_nt = c_weak_t - 1'b1;
   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [PC_W-1:0]  target;
      logic [CNT_W-1:0] cnt;
   } btb_entry_t;

   btb_entry_t entry_q [ENTRIES];
   btb_entry_t entry_d [ENTRIES];

   btb_entry_t w_rd_entry;
   btb_entry_t w_upd_entry;
   logic       w_rd_hit;
   logic       w_upd_hit;

   assign w_rd_entry  = entry_q[rd_idx];
   assign w_upd_entry = entry_q[upd_idx];
   assign w_rd_hit    = w_rd_entry.valid && (w_rd_entry.tag == rd_tag);
   assign w_upd_hit   = w_upd_entry.valid && (w_upd_entry.tag == upd_tag);

   // Lookup reads registered state only, so a same-cycle update is not visible
   always_comb begin
      rd_taken  = w_rd_hit & w_rd_entry.cnt[CNT_W-1];
      rd_target = rd_taken ? w_rd_entry.target : '0;
   end

   // Next table contents: train on a hit, allocate on a taken miss
   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         entry_d[i] = entry_q[i];
      end
      if (upd_en) begin
         if (w_upd_hit) begin
            if (upd_taken) begin
               if (w_upd_entry.cnt != c_cnt_max) begin
                  entry_d[upd_idx].cnt = w_upd_entry.cnt + 1'b1;
               end
               entry_d[upd_idx].target = upd_target;
            end else if (w_upd_entry.cnt != '0) begin
               entry_d[upd_idx].cnt = w_upd_entry.cnt - 1'b1;
            end
         end else if (upd_taken) begin
            entry_d[upd_idx] = '{valid: 1'b1, tag: upd_tag, target: upd_target, cnt: c_weak_t};
         end
      end
   end

   // Table storage, cleared to invalid / weakly-not-taken on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            entry_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: c_weak_nt};
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            entry_q[i] <= entry_d[i];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_unit
// Brief    : IF-stage prediction from the BTB, EX-stage resolve/redirect,
//            table training and branch/mispredict performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_unit
   import branch_pkg::*;
#(
   parameter int PC_W    = 9,
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 2,
   parameter int PERF_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PC_W-1:0]   IfPC,
   output logic              PredTaken,
   output logic [PC_W-1:0]   PredTarget,
   input  logic              ExValid,
   input  logic [PC_W-1:0]   Cur_PC,
   input  logic [31:0]       Imm,
   input  logic              Branch,
   input  logic              JalrSel,
   input  logic              Halt,
   input  logic [31:0]       AluResult,
   input  logic              ExPredTaken,
   input  logic [PC_W-1:0]   ExPredTarget,
   output logic [31:0]       PC_Imm,
   output logic [31:0]       PC_Four,
   output logic [31:0]       BrPC,
   output logic              PcSel,
   output logic              Mispredict,
   output logic [PERF_W-1:0] BranchCnt,
   output logic [PERF_W-1:0] MispredCnt
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;

   logic [31:0]       w_cur_pc_ext;
   logic              w_act_taken;
   logic [PC_W-1:0]   w_act_tgt;
   logic              w_upd_en;
   logic [PERF_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [PERF_W-1:0] mispred_cnt_q, mispred_cnt_d;

   // Fetch PC byte offset and the upper ALU bits never reach the table
   logic w_unused;
   assign w_unused = &{1'b0, IfPC[1:0], AluResult[31:PC_W]};

   assign w_cur_pc_ext = {{(32-PC_W){1'b0}}, Cur_PC};
   assign PC_Imm       = w_cur_pc_ext + Imm;
   assign PC_Four      = w_cur_pc_ext + 32'd4;

   // Actual outcome: jalr always taken and wins the target over the branch adder
   always_comb begin
      w_act_taken = JalrSel | (Branch & AluResult[0]);
      w_act_tgt   = JalrSel ? AluResult[PC_W-1:0] : PC_Imm[PC_W-1:0];
   end

   // Mispredict detection and redirect select; halt overrides everything
   always_comb begin
      Mispredict = 1'b0;
      PcSel      = 1'b0;
      BrPC       = '0;
      if (ExValid) begin
         if (Halt) begin
            PcSel = 1'b1;
            BrPC  = w_cur_pc_ext;
         end else begin
            Mispredict = (w_act_taken != ExPredTaken) |
                         (w_act_taken & ExPredTaken & (w_act_tgt != ExPredTarget));
            PcSel      = Mispredict;
            if (Mispredict) begin
               BrPC = w_act_taken ? {{(32-PC_W){1'b0}}, w_act_tgt} : PC_Four;
            end
         end
      end
   end

   assign w_upd_en = ExValid & (Branch | JalrSel) & ~Halt;

   branch_target_buffer #(
      .PC_W    (PC_W),
      .ENTRIES (ENTRIES),
      .CNT_W   (CNT_W)
   ) u_btb (
      .clk        (clk),
      .reset      (reset),
      .rd_idx     (IfPC[IDX_W+1:2]),
      .rd_tag     (IfPC[PC_W-1:IDX_W+2]),
      .rd_taken   (PredTaken),
      .rd_target  (PredTarget),
      .upd_en     (w_upd_en),
      .upd_idx    (Cur_PC[IDX_W+1:2]),
      .upd_tag    (Cur_PC[PC_W-1:IDX_W+2]),
      .upd_target (w_act_tgt),
      .upd_taken  (w_act_taken)
   );

   // Performance counters step by one per event and wrap naturally
   always_comb begin
      branch_cnt_d  = branch_cnt_q + PERF_W'(w_upd_en);
      mispred_cnt_d = mispred_cnt_q + PERF_W'(Mispredict);
   end

   // Performance counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign BranchCnt  = branch_cnt_q;
   assign MispredCnt = mispred_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_unit
// Brief    : Directed self-checking bench for branch_predict_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [8:0]  IfPC = '0;
   logic        ExValid = 1'b0;
   logic [8:0]  Cur_PC = '0;
   logic [31:0] Imm = '0;
   logic        Branch = 1'b0;
   logic        JalrSel = 1'b0;
   logic        Halt = 1'b0;
   logic [31:0] AluResult = '0;
   logic        ExPredTaken = 1'b0;
   logic [8:0]  ExPredTarget = '0;

   logic        PredTaken;
   logic [8:0]  PredTarget;
   logic [31:0] PC_Imm, PC_Four, BrPC;
   logic        PcSel, Mispredict;
   logic [31:0] BranchCnt, MispredCnt;

   logic        w2_pred_taken;
   logic [8:0]  w2_pred_target;
   logic [31:0] w2_pc_imm, w2_pc_four, w2_br_pc;
   logic        w2_pc_sel, w2_mispredict;
   logic [2:0]  w2_branch_cnt, w2_mispred_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   branch_predict_unit dut (
      .clk(clk), .reset(reset), .IfPC(IfPC), .PredTaken(PredTaken), .PredTarget(PredTarget),
      .ExValid(ExValid), .Cur_PC(Cur_PC), .Imm(Imm), .Branch(Branch), .JalrSel(JalrSel),
      .Halt(Halt), .AluResult(AluResult), .ExPredTaken(ExPredTaken), .ExPredTarget(ExPredTarget),
      .PC_Imm(PC_Imm), .PC_Four(PC_Four), .BrPC(BrPC), .PcSel(PcSel), .Mispredict(Mispredict),
      .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
   );

   // Narrow perf counters so wrap-around is reachable in a short run
   branch_predict_unit #(.PERF_W(3)) dut_wrap (
      .clk(clk), .reset(reset), .IfPC(IfPC), .PredTaken(w2_pred_taken), .PredTarget(w2_pred_target),
      .ExValid(ExValid), .Cur_PC(Cur_PC), .Imm(Imm), .Branch(Branch), .JalrSel(JalrSel),
      .Halt(Halt), .AluResult(AluResult), .ExPredTaken(ExPredTaken), .ExPredTarget(ExPredTarget),
      .PC_Imm(w2_pc_imm), .PC_Four(w2_pc_four), .BrPC(w2_br_pc), .PcSel(w2_pc_sel),
      .Mispredict(w2_mispredict), .BranchCnt(w2_branch_cnt), .MispredCnt(w2_mispred_cnt)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ex(input logic v, input logic [8:0] pc, input logic [31:0] imm,
                           input logic br, input logic jalr, input logic hlt,
                           input logic [31:0] alu, input logic ptk, input logic [8:0] ptg);
      ExValid = v; Cur_PC = pc; Imm = imm; Branch = br; JalrSel = jalr; Halt = hlt;
      AluResult = alu; ExPredTaken = ptk; ExPredTarget = ptg;
   endtask

   task automatic clear_ex;
      drive_ex(1'b0, 9'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 9'h000);
   endtask

   task automatic test_reset;
      IfPC = 9'h010;
      drive_ex(1'b0, 9'h010, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 9'h000);
      #1;
      checks++; if (PredTaken !== 1'b0) begin failures++; $display("FAIL reset_pred_taken: got %0h want 0", PredTaken); end
      checks++; if (BranchCnt !== 32'd0) begin failures++; $display("FAIL reset_branch_cnt: got %0d want 0", BranchCnt); end
      checks++; if (MispredCnt !== 32'd0) begin failures++; $display("FAIL reset_mispred_cnt: got %0d want 0", MispredCnt); end
      checks++; if (PC_Four !== 32'h14) begin failures++; $display("FAIL reset_pc_four: got %0h want 14", PC_Four); end
      checks++; if (PC_Imm !== 32'h30) begin failures++; $display("FAIL reset_pc_imm: got %0h want 30", PC_Imm); end
      tick();
      reset = 1'b0;
      clear_ex();
      tick();
   endtask

   task automatic test_cold_miss;
      IfPC = 9'h010;
      drive_ex(1'b1, 9'h010, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 9'h000);
      #1;
      checks++; if (PredTaken !== 1'b0) begin failures++; $display("FAIL cold_pred_taken: got %0h want 0", PredTaken); end
      checks++; if (Mispredict !== 1'b1) begin failures++; $display("FAIL cold_mispredict: got %0h want 1", Mispredict); end
      checks++; if (PcSel !== 1'b1) begin failures++; $display("FAIL cold_pcsel: got %0h want 1", PcSel); end
      checks++; if (BrPC !== 32'h30) begin failures++; $display("FAIL cold_brpc: got %0h want 30", BrPC); end
      tick();
      clear_ex();
      #1;
      checks++; if (PredTaken !== 1'b1) begin failures++; $display("FAIL cold_alloc_taken: got %0h want 1", PredTaken); end
      checks++; if (PredTarget !== 9'h030) begin failures++; $display("FAIL cold_alloc_target: got %0h want 30", PredTarget); end
      checks++; if (BranchCnt !== 32'd1 || MispredCnt !== 32'd1) begin failures++;
         $display("FAIL cold_counters: got %0d/%0d want 1/1", BranchCnt, MispredCnt); end
   endtask

   task automatic test_training;
      for (int i = 0; i < 3; i++) begin
         drive_ex(1'b1, 9'h010, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b1, 9'h030);
         #1;
         checks++; if (Mispredict !== 1'b0) begin failures++; $display("FAIL train_taken_mispredict[%0d]: got %0h want 0", i, Mispredict); end
         tick();
      end
      // counter now saturated: first not-taken keeps the prediction taken
      drive_ex(1'b1, 9'h010, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 9'h030);
      #1;
      checks++; if (BrPC !== 32'h14 || PcSel !== 1'b1) begin failures++;
         $display("FAIL train_nt_brpc: got %0h/%0h want 14/1", BrPC, PcSel); end
      tick();
      clear_ex();
      #1;
      checks++; if (PredTaken !== 1'b1) begin failures++; $display("FAIL train_after_nt1: got %0h want 1", PredTaken); end
      drive_ex(1'b1, 9'h010, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 9'h030);
      tick();
      clear_ex();
      #1;
      checks++; if (PredTaken !== 1'b0 || PredTarget !== 9'h000) begin failures++;
         $display("FAIL train_after_nt2: got %0h/%0h want 0/0", PredTaken, PredTarget); end
      checks++; if (BranchCnt !== 32'd6 || MispredCnt !== 32'd3) begin failures++;
         $display("FAIL train_counters: got %0d/%0d want 6/3", BranchCnt, MispredCnt); end
   endtask

   task automatic test_jalr;
      drive_ex(1'b1, 9'h020, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 9'h000);
      tick();
      clear_ex();
      IfPC = 9'h020;
      #1;
      checks++; if (PredTarget !== 9'h040) begin failures++; $display("FAIL jalr_setup_target: got %0h want 40", PredTarget); end
      drive_ex(1'b1, 9'h020, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0A0, 1'b1, 9'h040);
      #1;
      checks++; if (Mispredict !== 1'b1 || BrPC !== 32'hA0) begin failures++;
         $display("FAIL jalr_redirect: got %0h/%0h want 1/a0", Mispredict, BrPC); end
      tick();
      clear_ex();
      #1;
      checks++; if (PredTaken !== 1'b1 || PredTarget !== 9'h0A0) begin failures++;
         $display("FAIL jalr_target_update: got %0h/%0h want 1/a0", PredTaken, PredTarget); end
   endtask

   task automatic test_halt;
      IfPC = 9'h100;
      drive_ex(1'b1, 9'h100, 32'h20, 1'b1, 1'b0, 1'b1, 32'h1, 1'b0, 9'h000);
      #1;
      checks++; if (PcSel !== 1'b1 || BrPC !== 32'h100) begin failures++;
         $display("FAIL halt_redirect: got %0h/%0h want 1/100", PcSel, BrPC); end
      checks++; if (Mispredict !== 1'b0) begin failures++; $display("FAIL halt_mispredict: got %0h want 0", Mispredict); end
      tick();
      clear_ex();
      #1;
      checks++; if (PredTaken !== 1'b0) begin failures++; $display("FAIL halt_no_write: got %0h want 0", PredTaken); end
      checks++; if (BranchCnt !== 32'd8 || MispredCnt !== 32'd5) begin failures++;
         $display("FAIL halt_counters: got %0d/%0d want 8/5", BranchCnt, MispredCnt); end
   endtask

   task automatic test_alias;
      // 0x060 shares index 8 with 0x020 (strongly taken) but has a different tag
      IfPC = 9'h060;
      drive_ex(1'b1, 9'h060, 32'h10, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 9'h000);
      #1;
      checks++; if (PredTaken !== 1'b0) begin failures++; $display("FAIL alias_miss: got %0h want 0", PredTaken); end
      checks++; if (BrPC !== 32'h70) begin failures++; $display("FAIL alias_brpc: got %0h want 70", BrPC); end
      tick();
      clear_ex();
      #1;
      checks++; if (PredTaken !== 1'b1 || PredTarget !== 9'h070) begin failures++;
         $display("FAIL alias_alloc: got %0h/%0h want 1/70", PredTaken, PredTarget); end
      IfPC = 9'h020;
      #1;
      checks++; if (PredTaken !== 1'b0) begin failures++; $display("FAIL alias_evicted: got %0h want 0", PredTaken); end
      // a single not-taken must drop a weak-taken allocation below threshold
      IfPC = 9'h060;
      drive_ex(1'b1, 9'h060, 32'h10, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 9'h070);
      tick();
      clear_ex();
      #1;
      checks++; if (PredTaken !== 1'b0) begin failures++; $display("FAIL alias_weak_cnt: got %0h want 0", PredTaken); end
   endtask

   task automatic test_back_to_back;
      IfPC = 9'h030;
      drive_ex(1'b1, 9'h030, 32'h10, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 9'h000);
      #1;
      checks++; if (PredTaken !== 1'b0) begin failures++; $display("FAIL b2b_old_contents: got %0h want 0", PredTaken); end
      tick();
      clear_ex();
      #1;
      checks++; if (PredTaken !== 1'b1 || PredTarget !== 9'h040) begin failures++;
         $display("FAIL b2b_new_contents: got %0h/%0h want 1/40", PredTaken, PredTarget); end
      checks++; if (BranchCnt !== 32'd11 || MispredCnt !== 32'd8) begin failures++;
         $display("FAIL b2b_counters: got %0d/%0d want 11/8", BranchCnt, MispredCnt); end
   endtask

   task automatic test_stress;
      IfPC = 9'h010;
      drive_ex(1'b0, 9'h010, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 9'h000);
      #1;
      checks++; if (PcSel !== 1'b0 || Mispredict !== 1'b0 || BrPC !== 32'h0) begin failures++;
         $display("FAIL bubble_outputs: got %0h/%0h/%0h want 0/0/0", PcSel, Mispredict, BrPC); end
      checks++; if (PC_Imm !== 32'h30) begin failures++; $display("FAIL bubble_pc_imm: got %0h want 30", PC_Imm); end
      tick();
      clear_ex();
      #1;
      checks++; if (BranchCnt !== 32'd11 || MispredCnt !== 32'd8 || PredTaken !== 1'b0) begin failures++;
         $display("FAIL bubble_no_update: got %0d/%0d/%0h want 11/8/0", BranchCnt, MispredCnt, PredTaken); end
      drive_ex(1'b1, 9'h010, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 9'h000);
      tick();
      clear_ex();
      #1;
      checks++; if (PredTaken !== 1'b1 || BranchCnt !== 32'd12 || MispredCnt !== 32'd9) begin failures++;
         $display("FAIL pre_reset_state: got %0h/%0d/%0d want 1/12/9", PredTaken, BranchCnt, MispredCnt); end
      // reset lands while a taken resolve at 0x080 is waiting for the edge
      drive_ex(1'b1, 9'h080, 32'h10, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 9'h000);
      #1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      clear_ex();
      #1;
      checks++; if (PredTaken !== 1'b0) begin failures++; $display("FAIL reset_clears_0x010: got %0h want 0", PredTaken); end
      IfPC = 9'h080;
      #1;
      checks++; if (PredTaken !== 1'b0) begin failures++; $display("FAIL reset_drops_pending: got %0h want 0", PredTaken); end
      IfPC = 9'h030;
      #1;
      checks++; if (PredTaken !== 1'b0) begin failures++; $display("FAIL reset_clears_0x030: got %0h want 0", PredTaken); end
      checks++; if (BranchCnt !== 32'd0 || MispredCnt !== 32'd0) begin failures++;
         $display("FAIL reset_mid_counters: got %0d/%0d want 0/0", BranchCnt, MispredCnt); end
      // non-branch carrying a taken prediction: mispredict with no table update
      for (int i = 0; i < 8; i++) begin
         drive_ex(1'b1, 9'h010, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 9'h030);
         if (i == 0) begin
            #1;
            checks++; if (Mispredict !== 1'b1 || BrPC !== 32'h14) begin failures++;
               $display("FAIL nonbranch_mispredict: got %0h/%0h want 1/14", Mispredict, BrPC); end
         end
         tick();
         if (i == 6) begin
            checks++; if (w2_mispred_cnt !== 3'd7) begin failures++;
               $display("FAIL wrap_near_max: got %0d want 7", w2_mispred_cnt); end
         end
      end
      clear_ex();
      #1;
      checks++; if (w2_mispred_cnt !== 3'd0) begin failures++; $display("FAIL wrap_to_zero: got %0d want 0", w2_mispred_cnt); end
      checks++; if (MispredCnt !== 32'd8 || BranchCnt !== 32'd0) begin failures++;
         $display("FAIL wrap_wide_counters: got %0d/%0d want 8/0", MispredCnt, BranchCnt); end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_training();
      test_jalr();
      test_halt();
      test_alias();
      test_back_to_back();
      test_stress();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
